// File: rtl/icache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    MEM_RD,
    FILL
  } state_t;

  function automatic int woff_w(input int block_words);
    return $clog2(block_words);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int num_lines, input int block_words);
    return addr_w - 2 - woff_w(block_words) - idx_w(num_lines);
  endfunction

  // Block address = {tag, idx}, i.e. the byte address without offset bits.
  function automatic int maddr_w(input int addr_w, input int block_words);
    return addr_w - 2 - woff_w(block_words);
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the cache lines: one synchronous write port,
// one combinational read port.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES   = 8,
  parameter int BLOCK_WORDS = 4,
  parameter int TAG_W       = 3,
  localparam int IDX_W      = idx_w(NUM_LINES),
  localparam int BLK_W      = WORD_W * BLOCK_WORDS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [TAG_W-1:0] wtag,
  input  logic [BLK_W-1:0] wblock,
  input  logic [IDX_W-1:0] ridx,
  output logic             rvalid,
  output logic [TAG_W-1:0] rtag,
  output logic [BLK_W-1:0] rblock
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [BLK_W-1:0]     data_q [NUM_LINES];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[widx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are not reset; the valid bits alone qualify them,
  // which keeps the arrays mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wblock;
    end
  end

  assign rvalid = valid_q[ridx];
  assign rtag   = tag_q[ridx];
  assign rblock = data_q[ridx];

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache: same-cycle hits, block refill on a miss
// with BUSYWAIT stalling the CPU until the line is written.
module icache_direct_mapped
  import icache_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int NUM_LINES   = 8,
  parameter int BLOCK_WORDS = 4,
  localparam int MA_W       = maddr_w(ADDR_W, BLOCK_WORDS)
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [31:0]                     PC,
  output logic [31:0]                     INSTRUCTION,
  output logic                            BUSYWAIT,
  output logic                            MEM_READ,
  output logic [MA_W-1:0]                 MEM_ADDRESS,
  input  logic [WORD_W*BLOCK_WORDS-1:0]   MEM_READDATA,
  input  logic                            MEM_BUSYWAIT
);

  localparam int WOFF_W = woff_w(BLOCK_WORDS);
  localparam int IDX_W  = idx_w(NUM_LINES);
  localparam int TAG_W  = tag_w(ADDR_W, NUM_LINES, BLOCK_WORDS);
  localparam int WSEL_W = (WOFF_W > 0) ? WOFF_W : 1;
  localparam int BLK_W  = WORD_W * BLOCK_WORDS;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_a;
  logic [MA_W-1:0]   pc_blk;
  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic [WSEL_W-1:0] pc_woff;

  logic [MA_W-1:0]   fill_addr_q;
  logic [BLK_W-1:0]  fill_buf_q;
  logic [31:0]       last_instr_q;

  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [BLK_W-1:0]  line_block;
  logic [WORD_W-1:0] line_words [BLOCK_WORDS];
  logic              hit;
  logic [WORD_W-1:0] hit_word;

  // Upper PC bits are dropped, so addresses alias modulo 2^ADDR_W.
  assign pc_a    = PC[ADDR_W-1:0];
  assign pc_blk  = MA_W'(pc_a >> (2 + WOFF_W));
  assign pc_idx  = pc_blk[IDX_W-1:0];
  assign pc_tag  = pc_blk[MA_W-1:IDX_W];
  assign pc_woff = WSEL_W'((pc_a >> 2) & ADDR_W'(BLOCK_WORDS - 1));

  icache_line_array #(
    .NUM_LINES  (NUM_LINES),
    .BLOCK_WORDS(BLOCK_WORDS),
    .TAG_W      (TAG_W)
  ) u_lines (
    .clk   (CLK),
    .reset (RESET),
    .we    (state_q == FILL),
    .widx  (fill_addr_q[IDX_W-1:0]),
    .wtag  (fill_addr_q[MA_W-1:IDX_W]),
    .wblock(fill_buf_q),
    .ridx  (pc_idx),
    .rvalid(line_valid),
    .rtag  (line_tag),
    .rblock(line_block)
  );

  always_comb begin
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      line_words[i] = line_block[i*WORD_W +: WORD_W];
    end
  end

  assign hit      = line_valid && (line_tag == pc_tag);
  assign hit_word = line_words[pc_woff];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      fill_addr_q  <= '0;
      last_instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && !hit) fill_addr_q  <= pc_blk;
      if (state_q == IDLE && hit)  last_instr_q <= hit_word;
    end
  end

  // Only the capture edge looks at MEM_READDATA, so X/Z elsewhere is harmless.
  always_ff @(posedge CLK) begin
    if (state_q == MEM_RD && !MEM_BUSYWAIT) fill_buf_q <= MEM_READDATA;
  end

  // NOTE: combinational blocks use blocking '=' and assign a default first,
  // so every path drives every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!hit) state_d = MEM_RD;
      MEM_RD:  if (!MEM_BUSYWAIT) state_d = FILL;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    MEM_READ    = (state_q == MEM_RD);
    MEM_ADDRESS = fill_addr_q;
    BUSYWAIT    = !RESET && ((state_q != IDLE) || !hit);
    INSTRUCTION = last_instr_q;
    if (RESET) begin
      INSTRUCTION = '0;
    end else if (state_q == IDLE && hit) begin
      INSTRUCTION = hit_word;
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed self-checking bench for icache_direct_mapped with a
// configurable-latency block memory model.
module tb_icache_direct_mapped;

  logic         CLK;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int checks = 0;
  int errors = 0;
  int mem_lat = 5;
  int rd_cnt = 0;

  icache_direct_mapped #(
    .ADDR_W(10),
    .NUM_LINES(8),
    .BLOCK_WORDS(4)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PC          (PC),
    .INSTRUCTION (INSTRUCTION),
    .BUSYWAIT    (BUSYWAIT),
    .MEM_READ    (MEM_READ),
    .MEM_ADDRESS (MEM_ADDRESS),
    .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input int widx);
    return 32'h0004_0005 + 32'(widx) * 32'h0001_0101;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    logic [31:0] a;
    a = pc & 32'h3FF;
    return mem_word(int'(a >> 2));
  endfunction

  // Memory: a read lasts mem_lat cycles, busy for all but the last one.
  always @(posedge CLK) begin
    if (!MEM_READ) rd_cnt <= 0;
    else           rd_cnt <= rd_cnt + 1;
  end

  assign MEM_BUSYWAIT = MEM_READ && (rd_cnt < mem_lat - 1);

  always_comb begin
    MEM_READDATA = 'x;
    if (MEM_READ && !MEM_BUSYWAIT) begin
      for (int w = 0; w < 4; w++) begin
        MEM_READDATA[w*32 +: 32] = mem_word(int'(MEM_ADDRESS) * 4 + w);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_miss(input logic [31:0] pc, input int exp_blk, input int exp_cycles,
                         input string name);
    int n;
    PC = pc;
    #1;
    checks++;
    if (BUSYWAIT !== 1'b1) begin
      errors++;
      $display("FAIL %s miss_busywait: got %0b want 1", name, BUSYWAIT);
    end
    step();
    checks++;
    if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'(exp_blk)) begin
      errors++;
      $display("FAIL %s mem_req: MEM_READ=%0b MEM_ADDRESS=%0d want 1/%0d",
               name, MEM_READ, MEM_ADDRESS, exp_blk);
    end
    n = 1;
    while (BUSYWAIT && n < 40) begin
      n++;
      step();
    end
    checks++;
    if (n != exp_cycles) begin
      errors++;
      $display("FAIL %s penalty: got %0d busy cycles want %0d", name, n, exp_cycles);
    end
    checks++;
    if (INSTRUCTION !== exp_word(pc) || MEM_READ !== 1'b0) begin
      errors++;
      $display("FAIL %s fill_word: INSTRUCTION=%h MEM_READ=%0b want %h/0",
               name, INSTRUCTION, MEM_READ, exp_word(pc));
    end
  endtask

  task automatic expect_hit(input logic [31:0] pc, input string name);
    PC = pc;
    #1;
    checks++;
    if (BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0 || INSTRUCTION !== exp_word(pc)) begin
      errors++;
      $display("FAIL %s hit: BUSYWAIT=%0b MEM_READ=%0b INSTRUCTION=%h want 0/0/%h",
               name, BUSYWAIT, MEM_READ, INSTRUCTION, exp_word(pc));
    end
    step();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    PC = 32'h0;
    repeat (3) step();
    checks++;
    if (BUSYWAIT !== 1'b0 || MEM_READ !== 1'b0 || INSTRUCTION !== 32'h0 || MEM_ADDRESS !== 6'h0) begin
      errors++;
      $display("FAIL reset_state: BUSYWAIT=%0b MEM_READ=%0b INSTRUCTION=%h MEM_ADDRESS=%0d want 0/0/0/0",
               BUSYWAIT, MEM_READ, INSTRUCTION, MEM_ADDRESS);
    end
    RESET = 1'b0;
  endtask

  task automatic test_cold_and_spatial();
    do_miss(32'h000, 0, 7, "cold");
    expect_hit(32'h004, "spatial_w1");
    expect_hit(32'h008, "spatial_w2");
    expect_hit(32'h00C, "spatial_w3");
  endtask

  task automatic test_conflict_alias();
    do_miss(32'h080, 8, 7, "conflict_in");
    expect_hit(32'h084, "conflict_hit");
    do_miss(32'h000, 0, 7, "conflict_back");
    expect_hit(32'h400, "alias_0x400");
    expect_hit(32'h40C, "alias_0x40c");
  endtask

  task automatic test_reset_mid_fill();
    PC = 32'h010;
    #1;
    step();
    step();
    step();
    RESET = 1'b1;
    #1;
    checks++;
    if (BUSYWAIT !== 1'b0 || MEM_READ !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: BUSYWAIT=%0b MEM_READ=%0b want 0/1", BUSYWAIT, MEM_READ);
    end
    step();
    checks++;
    if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0 || INSTRUCTION !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_post: MEM_READ=%0b BUSYWAIT=%0b INSTRUCTION=%h want 0/0/0",
               MEM_READ, BUSYWAIT, INSTRUCTION);
    end
    RESET = 1'b0;
    do_miss(32'h010, 1, 7, "rst_mid_refetch");
  endtask

  task automatic test_zero_latency();
    mem_lat = 0;
    do_miss(32'h020, 2, 3, "zero_lat");
    expect_hit(32'h024, "zero_lat_hit");
  endtask

  task automatic test_back_to_back();
    do_miss(32'h040, 4, 3, "b2b_first");
    do_miss(32'h06C, 6, 3, "b2b_second");
    expect_hit(32'h048, "b2b_line4_kept");
    expect_hit(32'h014, "b2b_line1_kept");
  endtask

  initial begin
    RESET = 1'b1;
    PC = 32'h0;
    test_reset();
    test_cold_and_spatial();
    test_conflict_alias();
    test_reset_mid_fill();
    test_zero_latency();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
